wb_cfg: RTL and testbench
=========================

Name: wb_cfg

Overview:
- Wishbone classic slave that gives the management SoC read/write access to the weight/bias memories of the wake-word DNN (conv1, conv2, fc).
- Converts 32-bit bus words into wide memory vectors through per-region staging registers.
- Drives single-cycle read/write strobes plus bank/address to the accelerator.
- Sits between the SoC Wishbone bus and the word-recognition accelerator, inside the top level.

Parameters:
- CONV1_BANK_BW, 3, conv1 bank select width
- CONV1_ADDR_BW, 3, conv1 address width
- CONV1_VECTOR_BW, 104, conv1 vector width (4 bus words; word 3 uses bits [7:0])
- CONV2_BANK_BW, 3, conv2 bank select width
- CONV2_ADDR_BW, 4, conv2 address width
- CONV2_VECTOR_BW, 64, conv2 vector width (2 bus words)
- FC_BANK_BW, 2, fc bank select width
- FC_ADDR_BW, 8, fc address width
- FC_BIAS_BW, 32, fc data width (1 bus word)
- WISHBONE_BASE_ADDR, 32'h30000000, base of the 256 KiB window

Ports:
- clk_i in 1 clock
- rst_i in 1 reset; one clock, reset is synchronous and active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i in 1 each: Wishbone strobe, cycle, write enable
- wbs_sel_i in 4 byte select (ignored; full-word accesses only)
- wbs_dat_i in 32 write data
- wbs_adr_i in 32 byte address
- wbs_ack_o out 1 acknowledge
- wbs_dat_o out 32 read data
- conv1_rd_en_o, conv1_wr_en_o out 1 each
- conv1_rd_wr_bank_o out CONV1_BANK_BW
- conv1_rd_wr_addr_o out CONV1_ADDR_BW
- conv1_wr_data_o out CONV1_VECTOR_BW
- conv1_rd_data_i in CONV1_VECTOR_BW
- conv2_*: same port set as conv1, with CONV2_* widths
- fc_*: same port set as conv1, with FC_BANK_BW / FC_ADDR_BW / FC_BIAS_BW widths

Behaviour:
- Address decode, with off = wbs_adr_i - WISHBONE_BASE_ADDR:
  - Request is selected only when wbs_adr_i[31:18] == base[31:18]; unselected requests are never acked.
  - off[1:0] ignored.
  - off[3:2] = word index; word 0 = vector bits [31:0].
  - off[11:4] = memory address, truncated to region ADDR_BW.
  - off[14:12] = bank, truncated to region BANK_BW.
  - off[17:16] = region: 0 conv1, 1 conv2, 2 fc, 3 reserved.
- Request accepted in IDLE when stb&cyc&selected.
- FSM states:
  - IDLE
  - WR_ACK
  - RD_REQ
  - RD_WAIT
  - RD_ACK
- Write path (IDLE -> WR_ACK -> IDLE):
  - Word goes into that region's staging register at the word index.
  - If the word index is the region's last word (conv1 3, conv2 1, fc 0), wr_en pulses for exactly one cycle, during the WR_ACK cycle.
  - That pulse carries the decoded bank/addr and wr_data = staging including the new word.
  - Ack is high during WR_ACK, i.e. 1 cycle after acceptance.
- Read path (IDLE -> RD_REQ -> RD_WAIT -> RD_ACK -> IDLE):
  - rd_en and bank/addr driven in RD_REQ.
  - Memory returns rd_data one cycle later; captured in RD_WAIT.
  - wbs_dat_o = selected word, zero-extended (conv1 word 3 = {24'b0, data[103:96]}).
  - Ack is high in RD_ACK, i.e. 3 cycles after acceptance.
- Reserved region or word index beyond the vector (conv2 >= 2, fc >= 1):
  - Write: acked, no staging change, no wr_en.
  - Read: acked with 0 via the normal read timing, no rd_en.
- wbs_ack_o is a single-cycle pulse. No new request is accepted in the ack cycle; the earliest next acceptance is the cycle after.
- Only one rd_en/wr_en is ever high at a time, across all regions.
- bank/addr outputs hold their last value between accesses.
- wbs_dat_o holds its last read value; writes do not alter it.
- cyc/stb dropped mid-transaction: the transaction still completes internally (memory op and ack pulse); the master ignores the ack.
- Reset (synchronous, active-high):
  - FSM -> IDLE.
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - All rd_en/wr_en = 0; all bank/addr/wr_data = 0.
  - Staging registers = 0.
  - Reset mid-transaction aborts it with no ack.

Decomposition:
- Package wb_cfg_pkg holds:
  - FSM state enum
  - region codes
  - address field bit positions (word [3:2], addr [11:4], bank [14:12], region [17:16], window [31:18])
  - last-word index per region
- One natural sub-module, wb_cfg_region: a parameterized staging register, last-word commit, read-word mux and zero-extend. Instantiated three times (conv1, conv2, fc).

Test Plan:
- Reset: hold rst_i 2 cycles -> ack, all enables, dat_o, wr_data all 0.
- conv1 write: write 0x11111111, 0x22222222, 0x33333333, 0x000000AB to 0x30002050..0x3000205C.
  - -> conv1_wr_en_o pulses once, on the last word only.
  - bank=2, addr=5, wr_data=104'hAB_33333333_22222222_11111111.
  - Each ack arrives 1 cycle after acceptance.
- conv2 read: read 0x30011034 with conv2_rd_data_i = 64'hDEADBEEF_CAFEF00D.
  - -> conv2_rd_en_o 1 cycle, bank=1, addr=3.
  - ack 3 cycles after acceptance; wbs_dat_o = 0xDEADBEEF.
- fc write then read at 0x30023FF0 (bank 3, addr 255):
  - write 0x80000001 -> fc_wr_en_o pulse with data 0x80000001.
  - readback returns 0x80000001 when memory echoes it.
- Boundaries:
  - write to 0x30030000 (reserved) -> acked, no wr_en.
  - read of conv1 word 3 with rd_data[103:96]=0xFF -> 0x000000FF.
  - access at 0x40000000 -> no ack.
- Back-to-back: a write and a read issued consecutively -> the second is accepted only after the first ack; rd_en and wr_en are never simultaneously high.

Source files
------------

// File: rtl/wb_cfg_pkg.sv
// Shared types and address-map constants for the Wishbone DNN weight/bias
// configuration slave.
package wb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ACK,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_ACK
  } state_t;

  typedef enum logic [1:0] {
    REG_CONV1 = 2'd0,
    REG_CONV2 = 2'd1,
    REG_FC    = 2'd2,
    REG_RSVD  = 2'd3
  } region_t;

  // Byte-offset field positions inside the 256 KiB window
  localparam int WORD_LSB   = 2;
  localparam int WORD_MSB   = 3;
  localparam int ADDR_LSB   = 4;
  localparam int ADDR_MSB   = 11;
  localparam int BANK_LSB   = 12;
  localparam int BANK_MSB   = 14;
  localparam int REGION_LSB = 16;
  localparam int REGION_MSB = 17;
  localparam int WINDOW_LSB = 18;

  localparam int ADDR_FIELD_BW = ADDR_MSB - ADDR_LSB + 1;
  localparam int BANK_FIELD_BW = BANK_MSB - BANK_LSB + 1;

  localparam int CONV1_LAST_WORD = 3;
  localparam int CONV2_LAST_WORD = 1;
  localparam int FC_LAST_WORD    = 0;

endpackage

// File: rtl/wb_cfg_if.sv
// Wishbone classic bus bundle between the management SoC and wb_cfg.
interface wb_cfg_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_cfg_region.sv
// One memory region: 32-bit word staging into a wide vector, last-word commit
// strobe, read strobe, and zero-extended read-word selection.
module wb_cfg_region
  import wb_cfg_pkg::*;
#(
  parameter int BANK_BW   = 3,
  parameter int ADDR_BW   = 3,
  parameter int VECTOR_BW = 104,
  parameter int LAST_WORD = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_stb,
  input  logic                     rd_stb,
  input  logic [1:0]               word_idx,
  input  logic [BANK_FIELD_BW-1:0] bank_field,
  input  logic [ADDR_FIELD_BW-1:0] addr_field,
  input  logic [31:0]              wr_word,
  input  logic [1:0]               rd_word_idx,
  input  logic [VECTOR_BW-1:0]     rd_data,
  output logic                     rd_en,
  output logic                     wr_en,
  output logic [BANK_BW-1:0]       bank,
  output logic [ADDR_BW-1:0]       addr,
  output logic [VECTOR_BW-1:0]     wr_data,
  output logic [31:0]              rd_word
);

  localparam int NW     = LAST_WORD + 1;
  localparam int PAD_BW = NW * 32;

  logic [VECTOR_BW-1:0] stage_q;
  logic [VECTOR_BW-1:0] stage_next;
  logic [PAD_BW-1:0]    stage_pad;
  logic [PAD_BW-1:0]    rd_pad;
  logic                 in_range;
  logic                 is_last;
  logic                 unused_bits;

  assign in_range = (int'(word_idx) <= LAST_WORD);
  assign is_last  = (int'(word_idx) == LAST_WORD);

  // Padding to whole bus words lets the partial top word truncate naturally
  always_comb begin
    stage_pad = PAD_BW'(stage_q);
    for (int w = 0; w < NW; w++) begin
      if (word_idx == 2'(w)) stage_pad[w*32 +: 32] = wr_word;
    end
  end

  assign stage_next = stage_pad[VECTOR_BW-1:0];
  assign rd_pad     = PAD_BW'(rd_data);

  always_comb begin
    rd_word = '0;
    for (int w = 0; w < NW; w++) begin
      if (rd_word_idx == 2'(w)) rd_word = rd_pad[w*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      bank    <= '0;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      if (wr_stb && in_range) begin
        stage_q <= stage_next;
        if (is_last) begin
          wr_en   <= 1'b1;
          bank    <= bank_field[BANK_BW-1:0];
          addr    <= addr_field[ADDR_BW-1:0];
          wr_data <= stage_next;
        end
      end
      if (rd_stb && in_range) begin
        rd_en <= 1'b1;
        bank  <= bank_field[BANK_BW-1:0];
        addr  <= addr_field[ADDR_BW-1:0];
      end
    end
  end

  assign unused_bits = ^{stage_pad, bank_field, addr_field};

endmodule

// File: rtl/wb_cfg.sv
// Wishbone classic slave giving the SoC access to the wake-word DNN conv1,
// conv2 and fc weight/bias memories through per-region staging registers.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for stb & cyc inside the window
// ST_WR_ACK  | write acked; commit strobe high if last word
// ST_RD_REQ  | rd_en and bank/addr presented to the memory
// ST_RD_WAIT | memory data valid, captured into the read register
// ST_RD_ACK  | read acked with the selected word
module wb_cfg
  import wb_cfg_pkg::*;
#(
  parameter int          CONV1_BANK_BW      = 3,
  parameter int          CONV1_ADDR_BW      = 3,
  parameter int          CONV1_VECTOR_BW    = 104,
  parameter int          CONV2_BANK_BW      = 3,
  parameter int          CONV2_ADDR_BW      = 4,
  parameter int          CONV2_VECTOR_BW    = 64,
  parameter int          FC_BANK_BW         = 2,
  parameter int          FC_ADDR_BW         = 8,
  parameter int          FC_BIAS_BW         = 32,
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  wb_cfg_if.slave                    wb,
  output logic                       conv1_rd_en_o,
  output logic                       conv1_wr_en_o,
  output logic [CONV1_BANK_BW-1:0]   conv1_rd_wr_bank_o,
  output logic [CONV1_ADDR_BW-1:0]   conv1_rd_wr_addr_o,
  output logic [CONV1_VECTOR_BW-1:0] conv1_wr_data_o,
  input  logic [CONV1_VECTOR_BW-1:0] conv1_rd_data_i,
  output logic                       conv2_rd_en_o,
  output logic                       conv2_wr_en_o,
  output logic [CONV2_BANK_BW-1:0]   conv2_rd_wr_bank_o,
  output logic [CONV2_ADDR_BW-1:0]   conv2_rd_wr_addr_o,
  output logic [CONV2_VECTOR_BW-1:0] conv2_wr_data_o,
  input  logic [CONV2_VECTOR_BW-1:0] conv2_rd_data_i,
  output logic                       fc_rd_en_o,
  output logic                       fc_wr_en_o,
  output logic [FC_BANK_BW-1:0]      fc_rd_wr_bank_o,
  output logic [FC_ADDR_BW-1:0]      fc_rd_wr_addr_o,
  output logic [FC_BIAS_BW-1:0]      fc_wr_data_o,
  input  logic [FC_BIAS_BW-1:0]      fc_rd_data_i
);

  state_t                   state, state_nxt;
  logic [31:0]              off;
  logic                     selected;
  logic [1:0]               word_idx;
  logic [ADDR_FIELD_BW-1:0] addr_field;
  logic [BANK_FIELD_BW-1:0] bank_field;
  region_t                  region;
  logic                     accept_wr, accept_rd, capture;
  region_t                  req_region;
  logic [1:0]               req_word;
  logic [31:0]              dat_q;
  logic [31:0]              conv1_word, conv2_word, fc_word, rd_sel;
  logic                     unused_bits;

  assign off        = wb.wbs_adr_i - WISHBONE_BASE_ADDR;
  assign selected   = (wb.wbs_adr_i[31:WINDOW_LSB] == WISHBONE_BASE_ADDR[31:WINDOW_LSB]);
  assign word_idx   = off[WORD_MSB:WORD_LSB];
  assign addr_field = off[ADDR_MSB:ADDR_LSB];
  assign bank_field = off[BANK_MSB:BANK_LSB];
  assign region     = region_t'(off[REGION_MSB:REGION_LSB]);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wb.wbs_stb_i && wb.wbs_cyc_i && selected) begin
          if (wb.wbs_we_i) begin
            accept_wr = 1'b1;
            state_nxt = ST_WR_ACK;
          end else begin
            accept_rd = 1'b1;
            state_nxt = ST_RD_REQ;
          end
        end
      end
      ST_WR_ACK:  state_nxt = ST_IDLE;
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        capture   = 1'b1;
        state_nxt = ST_RD_ACK;
      end
      ST_RD_ACK:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Ack comes straight from the state register, so it is a clean one-cycle pulse
  assign wb.wbs_ack_o = (state == ST_WR_ACK) || (state == ST_RD_ACK);
  assign wb.wbs_dat_o = dat_q;

  always_comb begin
    rd_sel = '0;
    case (req_region)
      REG_CONV1: rd_sel = conv1_word;
      REG_CONV2: rd_sel = conv2_word;
      REG_FC:    rd_sel = fc_word;
      default:   rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_region <= REG_CONV1;
      req_word   <= '0;
      dat_q      <= '0;
    end else begin
      if (accept_rd) begin
        req_region <= region;
        req_word   <= word_idx;
      end
      if (capture) dat_q <= rd_sel;
    end
  end

  wb_cfg_region #(
    .BANK_BW(CONV1_BANK_BW), .ADDR_BW(CONV1_ADDR_BW),
    .VECTOR_BW(CONV1_VECTOR_BW), .LAST_WORD(CONV1_LAST_WORD)
  ) u_conv1 (
    .clk(clk_i), .rst(rst_i),
    .wr_stb(accept_wr && (region == REG_CONV1)),
    .rd_stb(accept_rd && (region == REG_CONV1)),
    .word_idx(word_idx), .bank_field(bank_field), .addr_field(addr_field),
    .wr_word(wb.wbs_dat_i), .rd_word_idx(req_word), .rd_data(conv1_rd_data_i),
    .rd_en(conv1_rd_en_o), .wr_en(conv1_wr_en_o),
    .bank(conv1_rd_wr_bank_o), .addr(conv1_rd_wr_addr_o),
    .wr_data(conv1_wr_data_o), .rd_word(conv1_word)
  );

  wb_cfg_region #(
    .BANK_BW(CONV2_BANK_BW), .ADDR_BW(CONV2_ADDR_BW),
    .VECTOR_BW(CONV2_VECTOR_BW), .LAST_WORD(CONV2_LAST_WORD)
  ) u_conv2 (
    .clk(clk_i), .rst(rst_i),
    .wr_stb(accept_wr && (region == REG_CONV2)),
    .rd_stb(accept_rd && (region == REG_CONV2)),
    .word_idx(word_idx), .bank_field(bank_field), .addr_field(addr_field),
    .wr_word(wb.wbs_dat_i), .rd_word_idx(req_word), .rd_data(conv2_rd_data_i),
    .rd_en(conv2_rd_en_o), .wr_en(conv2_wr_en_o),
    .bank(conv2_rd_wr_bank_o), .addr(conv2_rd_wr_addr_o),
    .wr_data(conv2_wr_data_o), .rd_word(conv2_word)
  );

  wb_cfg_region #(
    .BANK_BW(FC_BANK_BW), .ADDR_BW(FC_ADDR_BW),
    .VECTOR_BW(FC_BIAS_BW), .LAST_WORD(FC_LAST_WORD)
  ) u_fc (
    .clk(clk_i), .rst(rst_i),
    .wr_stb(accept_wr && (region == REG_FC)),
    .rd_stb(accept_rd && (region == REG_FC)),
    .word_idx(word_idx), .bank_field(bank_field), .addr_field(addr_field),
    .wr_word(wb.wbs_dat_i), .rd_word_idx(req_word), .rd_data(fc_rd_data_i),
    .rd_en(fc_rd_en_o), .wr_en(fc_wr_en_o),
    .bank(fc_rd_wr_bank_o), .addr(fc_rd_wr_addr_o),
    .wr_data(fc_wr_data_o), .rd_word(fc_word)
  );

  assign unused_bits = ^{off[31:WINDOW_LSB], off[15], off[1:0], wb.wbs_sel_i};

endmodule

// File: tb/tb_wb_cfg.sv
// Directed bench for wb_cfg: vector table of bus accesses plus hand-written
// reset, commit, back-to-back and mid-transaction reset sequences.
module tb_wb_cfg;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  wb_cfg_if bus();

  logic [103:0] mem = '0;
  logic         c1_rd, c1_wr, c2_rd, c2_wr, f_rd, f_wr;
  logic [2:0]   c1_bank, c2_bank;
  logic [1:0]   f_bank;
  logic [2:0]   c1_addr;
  logic [3:0]   c2_addr;
  logic [7:0]   f_addr;
  logic [103:0] c1_wdata;
  logic [63:0]  c2_wdata;
  logic [31:0]  f_wdata;

  wb_cfg dut (
    .clk_i(clk), .rst_i(rst_i), .wb(bus),
    .conv1_rd_en_o(c1_rd), .conv1_wr_en_o(c1_wr),
    .conv1_rd_wr_bank_o(c1_bank), .conv1_rd_wr_addr_o(c1_addr),
    .conv1_wr_data_o(c1_wdata), .conv1_rd_data_i(mem),
    .conv2_rd_en_o(c2_rd), .conv2_wr_en_o(c2_wr),
    .conv2_rd_wr_bank_o(c2_bank), .conv2_rd_wr_addr_o(c2_addr),
    .conv2_wr_data_o(c2_wdata), .conv2_rd_data_i(mem[63:0]),
    .fc_rd_en_o(f_rd), .fc_wr_en_o(f_wr),
    .fc_rd_wr_bank_o(f_bank), .fc_rd_wr_addr_o(f_addr),
    .fc_wr_data_o(f_wdata), .fc_rd_data_i(mem[31:0])
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int multi_en = 0;

  always @(negedge clk)
    if ($countones({c1_rd, c1_wr, c2_rd, c2_wr, f_rd, f_wr}) > 1) multi_en++;

  task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [31:0]  wdat;
    logic [103:0] mem;
    logic         exp_ack;
    int           exp_lat;
    logic [31:0]  exp_rdat;
    logic [2:0]   exp_wr;   // {fc, conv2, conv1}
    logic [2:0]   exp_rd;
    logic [10:0]  exp_ba;   // {bank, addr}
  } vec_t;

  vec_t vecs[13];

  function automatic logic [10:0] get_ba(input logic [2:0] mask);
    case (mask)
      3'b001:  return {c1_bank, 5'b0, c1_addr};
      3'b010:  return {c2_bank, 4'b0, c2_addr};
      3'b100:  return {1'b0, f_bank, f_addr};
      default: return '0;
    endcase
  endfunction

  task automatic bus_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                            output logic acked, output int lat, output logic [31:0] rdat,
                            output logic [2:0] wr_seen, output logic [2:0] rd_seen);
    acked = 1'b0; lat = 0; rdat = '0; wr_seen = '0; rd_seen = '0;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = wdat;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      wr_seen |= {f_wr, c2_wr, c1_wr};
      rd_seen |= {f_rd, c2_rd, c1_rd};
      if (bus.wbs_ack_o) begin
        acked = 1'b1; lat = c; rdat = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
  endtask

  logic        acked;
  int          lat, lat_w, lat_r;
  logic [31:0] rdat, last_rd;
  logic [2:0]  wr_seen, rd_seen;

  initial begin
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;

    vecs[0]  = '{1'b1, 32'h3000_2050, 32'h1111_1111, '0, 1'b1, 1, '0, 3'b000, 3'b000, '0};
    vecs[1]  = '{1'b1, 32'h3000_2054, 32'h2222_2222, '0, 1'b1, 1, '0, 3'b000, 3'b000, '0};
    vecs[2]  = '{1'b1, 32'h3000_2058, 32'h3333_3333, '0, 1'b1, 1, '0, 3'b000, 3'b000, '0};
    vecs[3]  = '{1'b1, 32'h3000_205C, 32'h0000_00AB, '0, 1'b1, 1, '0, 3'b001, 3'b000, {3'd2, 8'd5}};
    vecs[4]  = '{1'b0, 32'h3001_1034, '0, 104'hDEADBEEF_CAFEF00D, 1'b1, 3, 32'hDEAD_BEEF, 3'b000, 3'b010, {3'd1, 8'd3}};
    vecs[5]  = '{1'b1, 32'h3002_3FF0, 32'h8000_0001, '0, 1'b1, 1, '0, 3'b100, 3'b000, {3'd3, 8'hFF}};
    vecs[6]  = '{1'b0, 32'h3002_3FF0, '0, 104'h8000_0001, 1'b1, 3, 32'h8000_0001, 3'b000, 3'b100, {3'd3, 8'hFF}};
    vecs[7]  = '{1'b1, 32'h3003_0000, 32'hDEAD_BEEF, '0, 1'b1, 1, '0, 3'b000, 3'b000, '0};
    vecs[8]  = '{1'b0, 32'h3003_0004, '0, {104{1'b1}}, 1'b1, 3, 32'h0, 3'b000, 3'b000, '0};
    vecs[9]  = '{1'b0, 32'h3000_000C, '0, 104'hFF_00000000_00000000_00000000, 1'b1, 3, 32'h0000_00FF, 3'b000, 3'b001, {3'd0, 8'd0}};
    vecs[10] = '{1'b1, 32'h4000_0000, 32'h1, '0, 1'b0, 0, '0, 3'b000, 3'b000, '0};
    vecs[11] = '{1'b1, 32'h3001_0008, 32'hCAFE_BABE, '0, 1'b1, 1, '0, 3'b000, 3'b000, '0};
    vecs[12] = '{1'b0, 32'h3002_0004, '0, {104{1'b1}}, 1'b1, 3, 32'h0, 3'b000, 3'b000, '0};

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_ack", 104'(bus.wbs_ack_o), '0);
    chk("rst_dat", 104'(bus.wbs_dat_o), '0);
    chk("rst_en", 104'({c1_rd, c1_wr, c2_rd, c2_wr, f_rd, f_wr}), '0);
    chk("rst_c1_wdata", c1_wdata, '0);
    chk("rst_c2_wdata", 104'(c2_wdata), '0);
    chk("rst_fc_wdata", 104'(f_wdata), '0);
    chk("rst_ba", 104'({c1_bank, c1_addr, c2_bank, c2_addr, f_bank, f_addr}), '0);

    last_rd = '0;
    for (int i = 0; i < 13; i++) begin
      mem = vecs[i].mem;
      bus_access(vecs[i].we, vecs[i].adr, vecs[i].wdat, acked, lat, rdat, wr_seen, rd_seen);
      chk($sformatf("v%0d_ack", i), 104'(acked), 104'(vecs[i].exp_ack));
      chk($sformatf("v%0d_wr_en", i), 104'(wr_seen), 104'(vecs[i].exp_wr));
      chk($sformatf("v%0d_rd_en", i), 104'(rd_seen), 104'(vecs[i].exp_rd));
      if (vecs[i].exp_ack) begin
        chk($sformatf("v%0d_lat", i), 104'(lat), 104'(vecs[i].exp_lat));
        if (vecs[i].we) begin
          chk($sformatf("v%0d_dat_hold", i), 104'(rdat), 104'(last_rd));
        end else begin
          chk($sformatf("v%0d_rdat", i), 104'(rdat), 104'(vecs[i].exp_rdat));
          last_rd = vecs[i].exp_rdat;
        end
      end
      if ((vecs[i].exp_wr | vecs[i].exp_rd) != 3'b000)
        chk($sformatf("v%0d_bank_addr", i), 104'(get_ba(vecs[i].exp_wr | vecs[i].exp_rd)),
            104'(vecs[i].exp_ba));
    end

    // Committed vectors persist; out-of-range conv2 write left staging alone
    chk("c1_wdata", c1_wdata, 104'hAB_33333333_22222222_11111111);
    chk("fc_wdata", 104'(f_wdata), 104'h8000_0001);
    chk("c2_wdata_untouched", 104'(c2_wdata), '0);
    bus_access(1'b1, 32'h3001_0004, 32'h1234_5678, acked, lat, rdat, wr_seen, rd_seen);
    chk("c2_commit_en", 104'(wr_seen), 104'(3'b010));
    chk("c2_commit_data", 104'(c2_wdata), 104'h12345678_00000000);

    // Back-to-back: write then read with stb held through the write ack
    wr_seen = '0; rd_seen = '0; lat_w = 0; lat_r = 0; rdat = '0;
    @(negedge clk);
    mem = 104'hA5A5_A5A5;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 32'h3002_0000; bus.wbs_dat_i = 32'h5;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      wr_seen |= {f_wr, c2_wr, c1_wr};
      if (bus.wbs_ack_o) begin lat_w = c; break; end
    end
    bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h3000_0000;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      rd_seen |= {f_rd, c2_rd, c1_rd};
      if (bus.wbs_ack_o) begin lat_r = c; rdat = bus.wbs_dat_o; break; end
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    chk("b2b_wr_lat", 104'(lat_w), 104'(1));
    chk("b2b_rd_lat", 104'(lat_r), 104'(4));
    chk("b2b_rdat", 104'(rdat), 104'hA5A5_A5A5);
    chk("b2b_wr_en", 104'(wr_seen), 104'(3'b100));
    chk("b2b_rd_en", 104'(rd_seen), 104'(3'b001));

    // Reset during RD_REQ aborts the read without an ack
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h3000_0000;
    @(posedge clk); @(negedge clk);
    rst_i = 1'b1; bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_dat", 104'(bus.wbs_dat_o), '0);
    chk("midrst_rd_en", 104'(c1_rd), '0);
    acked = 1'b0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      if (bus.wbs_ack_o) acked = 1'b1;
    end
    chk("midrst_no_ack", 104'(acked), '0);

    chk("one_enable_at_a_time", 104'(multi_en), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
